sat_narrow_64to48: RTL and testbench
====================================

// Module: sat_narrow_64to48
// PURPOSE
//  Inverse of the multiplier's 48->64 sign-extension path: narrows a 64-bit product/accumulator
//  value back to the 48-bit operand width. Supports wrap (truncate) and saturate modes, in
//  signed or unsigned interpretation. Overflow is flagged per result, latched in a sticky bit
//  and counted. 2-stage pipeline with valid/ready handshake, between the 64-bit multiplier
//  output and the 48-bit writeback.
// PARAMETERS
//  IN_W   64  input width
//  OUT_W  48  output width; must be < IN_W
//  CNT_W  16  width of the overflow event counter
// PORTS
//  Clk         in   1      clock; everything is on the rising edge
//  Reset       in   1      synchronous, active-high reset
//  X           in   IN_W   value to narrow
//  Signed      in   1      1: two's complement; 0: unsigned
//  Saturate    in   1      1: clamp on overflow; 0: wrap (keep low OUT_W bits)
//  InValid     in   1      X/Signed/Saturate valid this cycle
//  InReady     out  1      block accepts the input this cycle
//  Y           out  OUT_W  narrowed result
//  Ovf         out  1      this result did not fit in OUT_W
//  OutValid    out  1      Y/Ovf valid
//  OutReady    in   1      consumer accepts Y/Ovf
//  ClearSticky in   1      clears OvfSticky and OvfCount
//  OvfSticky   out  1      set by any retired result with Ovf=1
//  OvfCount    out  CNT_W  count of retired results with Ovf=1; saturates at all-ones
// BEHAVIOUR
//  - Reset: stage valids=0, OutValid=0, Y=0, Ovf=0, OvfSticky=0, OvfCount=0. InReady=1 from
//    the first cycle after Reset drops. Reset mid-stream discards in-flight data silently.
//  - Fit check: signed fits iff X[IN_W-1:OUT_W-1] is all-0 or all-1; unsigned fits iff
//    X[IN_W-1:OUT_W]==0.
//  - Result: if fits or Saturate=0, Y=X[OUT_W-1:0]. If overflow and Saturate=1: signed
//    X[IN_W-1]=0 gives 0x7FFF_FFFF_FFFF, X[IN_W-1]=1 gives 0x8000_0000_0000; unsigned gives
//    0xFFFF_FFFF_FFFF. Ovf=~fits in both modes.
//  - Pipeline: S1 registers X/Signed/Saturate. S2 computes fit/result and registers Y/Ovf;
//    S2 valid drives OutValid. Latency is 2 cycles from the accepting edge to OutValid.
//    Throughput is 1/cycle when OutReady=1.
//  - Handshake: adv2 = ~S2valid | OutReady; InReady = ~S1valid | adv2 (combinational from
//    OutReady). Transfer happens on InValid&InReady and on OutValid&OutReady.
//    While OutValid=1 & OutReady=0, Y/Ovf/OutValid hold stable. No data is dropped or
//    duplicated. Inputs are ignored while InReady=0.
//  - Retire: one retire occurs on each OutValid&OutReady&Ovf. The retire sets OvfSticky and
//    increments OvfCount if it is not all-ones.
//  - ClearSticky has priority over a retire in the same cycle: both clear, and that retire
//    is not counted.
// STRUCTURE
//  - Shared package: IN_W/OUT_W defaults, SAT_POS/SAT_NEG/SAT_UMAX constants, function
//    fits(x,signed).
//  - One combinational sub-module, narrow_core: (X,Signed,Saturate)->(Y,Ovf). It is
//    instantiated in S2. Handshake, pipeline and counters stay in the top module.
// TESTING
//  1 Signed fit: X=0xFFFF_FFFF_FFFF_FFFE, Signed=1, Sat=1 -> Y=0xFFFF_FFFF_FFFE, Ovf=0,
//    OutValid 2 cycles after accept.
//  2 Signed pos sat: X=0x0000_8000_0000_0000, Signed=1, Sat=1 -> Y=0x7FFF_FFFF_FFFF, Ovf=1,
//    OvfSticky=1, OvfCount=1. Same X with Sat=0 -> Y=0x8000_0000_0000, Ovf=1.
//  3 Unsigned: X=0x0001_0000_0000_0000, Signed=0, Sat=1 -> Y=0xFFFF_FFFF_FFFF, Ovf=1.
//    X=0x0000_FFFF_FFFF_FFFF -> Y=same low 48 bits, Ovf=0.
//  4 Backpressure: stream 5 values with OutReady held 0 for 4 cycles -> InReady drops after
//    2 accepts. Y held stable. All 5 results emerge in order with no loss.
//  5 Counter: CNT_W=2, 5 overflowing retires -> OvfCount=3 (saturates). ClearSticky
//    together with a retire -> OvfCount=0, OvfSticky=0.
//  6 Reset mid-stream with 2 in flight -> OutValid=0 the next cycle, nothing emitted,
//    counters=0.

Source files
------------

// File: rtl/sat_narrow_64to48_pkg.sv
// Shared widths, saturation constants and the fit test for the 64->48 narrowing path.
// Pure declarations; no timing or handshake.
package sat_narrow_64to48_pkg;

    localparam int DEF_IN_W  = 64;
    localparam int DEF_OUT_W = 48;
    localparam int DEF_CNT_W = 16;

    localparam logic [DEF_OUT_W-1:0] SAT_POS  = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam logic [DEF_OUT_W-1:0] SAT_NEG  = {1'b1, {(DEF_OUT_W-1){1'b0}}};
    localparam logic [DEF_OUT_W-1:0] SAT_UMAX = {DEF_OUT_W{1'b1}};

    // Signed values fit when every bit from the new sign position up is a copy of it.
    function automatic logic fits(input logic [DEF_IN_W-1:0] x, input logic is_signed);
        if (is_signed)
            return (&x[DEF_IN_W-1:DEF_OUT_W-1]) | ~(|x[DEF_IN_W-1:DEF_OUT_W-1]);
        else
            return ~(|x[DEF_IN_W-1:DEF_OUT_W]);
    endfunction

endpackage

// File: rtl/sat_narrow_64to48_if.sv
// Input/output handshake bundle between the multiplier output and the writeback.
// master drives x/controls and out_ready; slave is the narrowing block.
interface sat_narrow_64to48_if #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 48
);
    logic [IN_W-1:0]  x;
    logic             is_signed;
    logic             saturate;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] y;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output x, is_signed, saturate, in_valid, out_ready,
        input  in_ready, y, ovf, out_valid
    );

    modport slave (
        input  x, is_signed, saturate, in_valid, out_ready,
        output in_ready, y, ovf, out_valid
    );
endinterface

// File: rtl/sat_narrow_64to48_narrow_core.sv
// Combinational narrowing: wrap or clamp a 64-bit value to 48 bits, flag overflow.
// Latency 0; no state, no backpressure.
module narrow_core
    import sat_narrow_64to48_pkg::*;
(
    input  logic [DEF_IN_W-1:0]  x,
    input  logic                 is_signed,
    input  logic                 saturate,
    output logic [DEF_OUT_W-1:0] y,
    output logic                 ovf
);
    logic fit;

    assign fit = fits(x, is_signed);
    assign ovf = ~fit;

    always_comb begin
        y = x[DEF_OUT_W-1:0];
        if (!fit && saturate) begin
            if (!is_signed)
                y = SAT_UMAX;
            else if (x[DEF_IN_W-1])
                y = SAT_NEG;
            else
                y = SAT_POS;
        end
    end
endmodule

// File: rtl/sat_narrow_64to48.sv
// Narrows multiplier results 64->48 (wrap/saturate, signed/unsigned) with sticky + counted overflow.
// Latency 2 cycles (S1 capture, S2 narrow+register); 1 result/cycle when out_ready stays high.
// Backpressure: S2 holds while out_ready=0, S1 fills, then in_ready drops (combinational from out_ready).
module sat_narrow_64to48
    import sat_narrow_64to48_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    sat_narrow_64to48_if.slave  bus,
    input  logic                clear_sticky,
    output logic                ovf_sticky,
    output logic [CNT_W-1:0]    ovf_count
);
    logic             s1_vld;
    logic [IN_W-1:0]  s1_x;
    logic             s1_sgn;
    logic             s1_sat;
    logic             s2_vld;
    logic [OUT_W-1:0] s2_y;
    logic             s2_ovf;
    logic [OUT_W-1:0] core_y;
    logic             core_ovf;
    logic             adv2;
    logic             retire;

    assign adv2         = ~s2_vld | bus.out_ready;
    assign bus.in_ready = ~s1_vld | adv2;
    assign bus.y        = s2_y;
    assign bus.ovf      = s2_ovf;
    assign bus.out_valid = s2_vld;
    assign retire       = s2_vld & bus.out_ready & s2_ovf;

    narrow_core u_core (
        .x         (s1_x),
        .is_signed (s1_sgn),
        .saturate  (s1_sat),
        .y         (core_y),
        .ovf       (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_x   <= '0;
            s1_sgn <= 1'b0;
            s1_sat <= 1'b0;
            s2_vld <= 1'b0;
            s2_y   <= '0;
            s2_ovf <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                s1_vld <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_x   <= bus.x;
                    s1_sgn <= bus.is_signed;
                    s1_sat <= bus.saturate;
                end
            end
            // S2 data only moves on a real transfer so y/ovf stay put while stalled or idle.
            if (adv2) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_y   <= core_y;
                    s2_ovf <= core_ovf;
                end
            end
        end
    end

    // A clear in the same cycle as a retire wins and swallows that retire.
    always_ff @(posedge clk) begin
        if (reset || clear_sticky) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (retire) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != {CNT_W{1'b1}})
                ovf_count <= ovf_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sat_narrow_64to48.sv
// Scoreboarded directed test of the 64->48 narrowing block (counter width 2 to reach saturation).
module tb_sat_narrow_64to48;
    localparam int CNT_W = 2;

    typedef struct {
        logic [47:0] y;
        logic        ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clear_sticky = 1'b0;
    logic             ovf_sticky;
    logic [CNT_W-1:0] ovf_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   mon_en = 1'b0;
    exp_t expq[$];

    logic             m_sticky = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    sat_narrow_64to48_if #(.IN_W(64), .OUT_W(48)) bus ();

    sat_narrow_64to48 #(.IN_W(64), .OUT_W(48), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .clear_sticky (clear_sticky),
        .ovf_sticky   (ovf_sticky),
        .ovf_count    (ovf_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compares outputs against the queue and tracks the sticky/count model.
    always @(negedge clk) begin
        exp_t e;
        logic ret;
        ret = 1'b0;
        if (reset) begin
            expq.delete();
            m_sticky = 1'b0;
            m_cnt    = '0;
        end else if (mon_en) begin
            chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
            chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=y:%h required=no_output", bus.y);
                end else begin
                    e = expq.pop_front();
                    chk("y", 64'(bus.y), 64'(e.y));
                    chk("ovf", 64'(bus.ovf), 64'(e.ovf));
                    ret = e.ovf;
                end
            end
            if (clear_sticky) begin
                m_sticky = 1'b0;
                m_cnt    = '0;
            end else if (ret) begin
                m_sticky = 1'b1;
                if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + CNT_W'(1);
            end
        end
    end

    task automatic send(input logic [63:0] xv, input logic sg, input logic sa,
                        input logic [47:0] ey, input logic eo);
        int  w = 0;
        bit  done = 1'b0;
        bus.x = xv;
        bus.is_signed = sg;
        bus.saturate = sa;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                expq.push_back('{ey, eo});
                acc_cyc = cyc;
                done = 1'b1;
            end else if (++w > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=in_ready_low required=accept");
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (expq.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 64'(expq.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.x = '0;
        bus.is_signed = 1'b0;
        bus.saturate = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_y", 64'(bus.y), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // 1: signed fit and latency
        send(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus.out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("latency", 64'(cyc - acc_cyc), 64'd2);
        end
        drain();

        // 2/3 and boundaries
        send(64'h0000_8000_0000_0000, 1'b1, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1);
        send(64'h0000_8000_0000_0000, 1'b1, 1'b0, 48'h8000_0000_0000, 1'b1);
        send(64'h0001_0000_0000_0000, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
        send(64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0);
        send(64'h8000_0000_0000_0000, 1'b1, 1'b1, 48'h8000_0000_0000, 1'b1);
        send(64'h0000_7FFF_FFFF_FFFF, 1'b1, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b0);
        send(64'hFFFF_8000_0000_0000, 1'b1, 1'b1, 48'h8000_0000_0000, 1'b0);
        send(64'hFFFF_7FFF_FFFF_FFFF, 1'b1, 1'b1, 48'h8000_0000_0000, 1'b1);
        send(64'h0001_0000_0000_0005, 1'b0, 1'b0, 48'h0000_0000_0005, 1'b1);
        drain();

        // 4: backpressure
        bus.out_ready = 1'b0;
        send(64'h0000_0000_0000_0011, 1'b0, 1'b0, 48'h0000_0000_0011, 1'b0);
        send(64'h0000_0000_0000_0022, 1'b1, 1'b0, 48'h0000_0000_0022, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_y", 64'(bus.y), 64'h11);
        bus.x = 64'hDEAD_BEEF_0000_0001;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_y_hold", 64'(bus.y), 64'h11);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        send(64'h0001_0000_0000_0033, 1'b0, 1'b0, 48'h0000_0000_0033, 1'b1);
        send(64'h0000_0000_0000_0044, 1'b0, 1'b1, 48'h0000_0000_0044, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FF55, 1'b1, 1'b0, 48'hFFFF_FFFF_FF55, 1'b0);
        drain();

        // 5: counter saturation and clear-vs-retire priority
        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("clr_count", 64'(ovf_count), 64'd0);
        @(posedge clk); #1;
        repeat (5) send(64'h0002_0000_0000_0000, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
        drain();
        @(negedge clk);
        chk("cnt_sat", 64'(ovf_count), 64'd3);
        chk("cnt_sticky", 64'(ovf_sticky), 64'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(64'h0000_8000_0000_0000, 1'b1, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus.out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk); #1;
        clear_sticky = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("clr_retire_count", 64'(ovf_count), 64'd0);
        chk("clr_retire_sticky", 64'(ovf_sticky), 64'd0);
        @(posedge clk); #1;

        // 6: reset mid-stream
        send(64'h0001_0000_0000_0000, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
        drain();
        bus.out_ready = 1'b0;
        send(64'h0004_0000_0000_0000, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
        send(64'h0000_0000_0000_0066, 1'b0, 1'b0, 48'h0000_0000_0066, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_count", 64'(ovf_count), 64'd0);
        chk("mid_rst_sticky", 64'(ovf_sticky), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_no_emit", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(64'h0000_0000_0000_0077, 1'b1, 1'b1, 48'h0000_0000_0077, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
